// File: rtl/sample_scheduler_if.sv
// Signal bundle between the audio sample scheduler and its host/datapath.
// master = host side driving pushes and control; slave = the scheduler itself.
interface sample_scheduler_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

  logic              play_in;
  logic              clr_in;
  logic [1:0]        rate_in;
  logic              wr_valid_in;
  logic [23:0]       audio0_in;
  logic [23:0]       audio1_in;
  logic              wr_ready_out;
  logic [23:0]       audio0_out;
  logic [23:0]       audio1_out;
  logic              tick_out;
  logic              irq_out;
  logic              underrun_out;
  logic [FILL_W-1:0] fill_out;

  modport master (
    output play_in, clr_in, rate_in, wr_valid_in, audio0_in, audio1_in,
    input  wr_ready_out, audio0_out, audio1_out, tick_out, irq_out,
           underrun_out, fill_out
  );

  modport slave (
    input  play_in, clr_in, rate_in, wr_valid_in, audio0_in, audio1_in,
    output wr_ready_out, audio0_out, audio1_out, tick_out, irq_out,
           underrun_out, fill_out
  );
endinterface

// File: rtl/sample_scheduler.sv
// Stereo sample scheduler: pair FIFO drained once per sample tick from a rate divider.
// Build option SAMPLE_SCHEDULER_UNDERRUN_REPEAT_EN: repeat the last pair on underrun (default drives zeros).
module sample_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int RATE_DIV0  = 1024,
  parameter int RATE_DIV1  = 512,
  parameter int RATE_DIV2  = 256,
  parameter int RATE_DIV3  = 128
) (
  input logic              clk,
  input logic              rst_n,
  sample_scheduler_if.slave bus
);

  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int FILL_W    = PTR_W + 1;
  localparam int MAX_DIV01 = (RATE_DIV0 > RATE_DIV1) ? RATE_DIV0 : RATE_DIV1;
  localparam int MAX_DIV23 = (RATE_DIV2 > RATE_DIV3) ? RATE_DIV2 : RATE_DIV3;
  localparam int MAX_DIV   = (MAX_DIV01 > MAX_DIV23) ? MAX_DIV01 : MAX_DIV23;
  localparam int CNT_W     = $clog2(MAX_DIV) + 1;

  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(FIFO_DEPTH);
  localparam logic [FILL_W-1:0] HALF_LVL = FILL_W'(FIFO_DEPTH / 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
  } pair_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        rate_q;
  logic              enter_run;
  logic              tick_evt;

  pair_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FILL_W-1:0] fill;
  pair_t             out_q;
  logic              tick_q;
  logic              irq_q;
  logic              underrun_q;
  logic              pop_d;

  logic              push;
  logic              pop;
  logic              starve;

  function automatic logic [CNT_W-1:0] div_reload(input logic [1:0] sel);
    logic [CNT_W-1:0] v;
    case (sel)
      2'd0:    v = CNT_W'(RATE_DIV0 - 1);
      2'd1:    v = CNT_W'(RATE_DIV1 - 1);
      2'd2:    v = CNT_W'(RATE_DIV2 - 1);
      default: v = CNT_W'(RATE_DIV3 - 1);
    endcase
    return v;
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    enter_run = 1'b0;
    tick_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.play_in) begin
          state_nxt = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        if (!bus.play_in)   state_nxt = IDLE;
        else if (cnt == '0) tick_evt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Rate is captured only on RUN entry; later rate_in changes wait for the next entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rate_q <= '0;
    end else if (enter_run) begin
      cnt    <= div_reload(bus.rate_in);
      rate_q <= bus.rate_in;
    end else if (state == RUN) begin
      if (!bus.play_in)  cnt <= '0;
      else if (tick_evt) cnt <= div_reload(rate_q);
      else               cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_evt;
  end

  // Clear wins over both sides of the FIFO in the same cycle.
  assign push   = bus.wr_valid_in && (fill < FULL_LVL) && !bus.clr_in;
  assign pop    = tick_evt && (fill != '0) && !bus.clr_in;
  assign starve = tick_evt && (fill == '0) && !bus.clr_in;

  // NOTE: sample storage has no reset; fill/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{left: bus.audio0_in, right: bus.audio1_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (bus.clr_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (bus.clr_in) begin
      out_q <= '0;
    end else if (pop) begin
      out_q <= mem[rd_ptr];
    end else if (starve) begin
`ifdef SAMPLE_SCHEDULER_UNDERRUN_REPEAT_EN
      out_q <= out_q;
`else
      out_q <= '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            underrun_q <= 1'b0;
    else if (bus.clr_in)   underrun_q <= 1'b0;
    else if (starve)       underrun_q <= 1'b1;
  end

  // Refill request is raised one cycle after a pop lands at or below half full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_d <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      pop_d <= pop;
      if (bus.clr_in)            irq_q <= 1'b0;
      else if (fill > HALF_LVL)  irq_q <= 1'b0;
      else if (pop_d)            irq_q <= 1'b1;
    end
  end

  assign bus.wr_ready_out = (fill < FULL_LVL);
  assign bus.audio0_out   = out_q.left;
  assign bus.audio1_out   = out_q.right;
  assign bus.tick_out     = tick_q;
  assign bus.irq_out      = irq_q;
  assign bus.underrun_out = underrun_q;
  assign bus.fill_out     = fill;

endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, stereo sample-pair FIFO depth (power of two, >=4).
REQ-002 Parameter RATE_DIV0..RATE_DIV3, defaults 1024/512/256/128, clk cycles per sample tick for rate_in = 0..3.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 play_in  input  1  level; 1 = stream samples, 0 = stop.
REQ-006 clr_in  input  1  one-cycle pulse; flush FIFO, clear irq and underrun status.
REQ-007 rate_in  input  2  sample-rate select.
REQ-008 wr_valid_in  input  1  push request for audio0_in/audio1_in pair.
REQ-009 audio0_in, audio1_in  input  24 each  left/right sample to push.
REQ-010 wr_ready_out  output  1  FIFO can accept a push this cycle.
REQ-011 audio0_out, audio1_out  output  24 each  current sample pair to the DSP datapath.
REQ-012 tick_out  output  1  one-cycle pulse per sample period; datapath samples audio outputs on it.
REQ-013 irq_out  output  1  level; FIFO refill request.
REQ-014 underrun_out  output  1  sticky; a tick found the FIFO empty.
REQ-015 fill_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 FSM states IDLE and RUN; IDLE->RUN when play_in=1, RUN->IDLE when play_in=0, transition on next clock edge.
REQ-017 On IDLE->RUN, divider counter loads RATE_DIV[rate_in]-1; rate_in changes while in RUN shall be ignored until next entry.
REQ-018 In RUN the counter decrements each cycle; at 0 it reloads RATE_DIV[latched rate]-1 and tick_out=1 for exactly that cycle.
REQ-019 First tick_out occurs exactly RATE_DIV cycles after the RUN-entry edge; period thereafter exactly RATE_DIV cycles.
REQ-020 On a tick with fill_out>0, the FIFO head pair is popped and registered onto audio0_out/audio1_out, valid in the same cycle tick_out=1.
REQ-021 On a tick with fill_out=0, underrun_out shall set and audio outputs follow REQ-033.
REQ-022 wr_ready_out = (fill_out < FIFO_DEPTH); a push occurs when wr_valid_in & wr_ready_out; wr_valid_in while full is dropped, no state change.
REQ-023 Push and pop in the same cycle: both performed, fill_out unchanged; at full, pop frees no slot for that same-cycle push (wr_ready_out already 0).
REQ-024 Read/write pointers wrap modulo FIFO_DEPTH; FIFO order strictly first-in first-out.
REQ-025 irq_out sets on the cycle after a pop leaves fill_out <= FIFO_DEPTH/2 with irq_out=0; stays set until clr_in or fill_out rises above FIFO_DEPTH/2.
REQ-026 clr_in: fill_out=0, pointers=0, irq_out=0, underrun_out=0, audio outputs=0 next cycle; FSM state and divider unaffected; clr_in overrides simultaneous push and pop.
REQ-027 RUN->IDLE: counter cleared, tick_out=0, FIFO contents and audio outputs retained.
REQ-028 Pushes are accepted in both IDLE and RUN.

Reset
REQ-029 While rst_n=0: state IDLE, counter 0, pointers 0, fill_out 0.
REQ-030 Reset outputs: audio0_out=0, audio1_out=0, tick_out=0, irq_out=0, underrun_out=0, wr_ready_out=1.
REQ-031 Reset asserted mid-RUN or mid-push shall abort immediately; no tick or push completes after rst_n falls.

Configuration
REQ-032 Macro SAMPLE_SCHEDULER_UNDERRUN_REPEAT_EN selects underrun output policy.
REQ-033 Defined: on underrun tick, audio0_out/audio1_out hold the last popped pair; undefined: both driven to 0 on that tick.

Verification
REQ-034 Reset with rst_n=0 asynchronously mid-RUN -> all outputs at REQ-030 values immediately, before next clock edge.
REQ-035 rate_in=3, push 3 pairs, play_in=1 -> tick_out every 128 cycles, first at cycle 128, pairs emerge in push order, fill_out 3->2->1->0.
REQ-036 FIFO_DEPTH=16, push 16 pairs -> wr_ready_out=0, 17th push dropped, fill_out=16; 8 pops -> irq_out=1 after 8th pop.
REQ-037 RUN with empty FIFO, last pair 0x123456/0xABCDEF -> underrun_out=1; outputs hold pair with macro, 0x000000 without.
REQ-038 Push and tick in the same cycle at fill_out=5 -> fill_out stays 5; clr_in with push pending -> fill_out=0, irq_out=0, underrun_out=0.
REQ-039 Change rate_in 3->0 in RUN -> period stays 128; drop play_in, re-raise -> period 1024.
